lrf_fusion_sequencer: RTL
=========================

Name: lrf_fusion_sequencer

Overview:
Central control block for the LRF multi-frame fusion datapath: the Sobel, HSSIM, Gauss and FUSION stages, the ping-pong average-map buffers, and the fused-frame buffer.
- Performs the AXI-Stream step handshake.
- Tracks beat and frame position within a fusion burst of 2*FUSE_COUNT frames.
- Issues every buffer enable/select at the correct pipeline-aligned beat.
- Delays tlast and stage-valid flags to the output.
- The datapath holds no control state of its own; it consumes this block's outputs.

Parameters:
PIXELS_PER_BEAT, 16, pixels per AXI beat (8 bits each)
IMAGE_DIM, 64, square frame edge in pixels; BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT
N_FUSE_COUNT, 4, FUSE_COUNT = 2**N_FUSE_COUNT; one burst = 2*FUSE_COUNT frames
SOBEL_DELAY, 10, beat index at which the average-buffer phase events fire
FUSED_DELAY, 23, beat index at which fused-buffer/output phase events fire; also the tlast delay
MAX_DELAY, 30, depth of the stage-valid chain

Ports:
s_axis_aclk  in  1  clock
s_axis_areset  in  1  asynchronous, active-high reset
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  last beat of input frame
s_axis_tready  out  1  equals m_axis_tready (combinational)
m_axis_tready  in  1  downstream ready
m_axis_tvalid  out  1  output beat valid
m_axis_tlast  out  1  last beat of output frame
step  out  1  pipeline advance enable for all datapath registers
frame_cnt  out  clog2(2*FUSE_COUNT)  current frame in burst
beat_cnt  out  clog2(BEATS)  current beat in frame
fused_src_sel  out  1  1: fused Sobel input takes s_axis_tdata (frame 0); 0: takes fused buffer
avg_first  out  1  average map bypass (use current emap)
avg_add  out  1  1: add current frame to average accumulator; 0: subtract
avg_en_a, avg_en_b  out  1 each  ping-pong average buffer enables (read and write)
avg_out_sel  out  1  1: average output taken from buffer A
fused_rd_en, fused_wr_en  out  1 each  fused buffer enables (already ANDed with step)
store_sel  out  1  1: fused buffer stores delayed raw frame; 0: stores FUSION output
stage_ok  out  MAX_DELAY  stage-valid chain; bit k set after k+1 steps since reset
frame_err  out  1  sticky: tlast seen at beat_cnt != BEATS-1

Behaviour:
- Reset values:
  - All counters and registers are 0, except avg_first=1 and avg_next=1.
  - Outputs m_axis_tvalid, m_axis_tlast, stage_ok, frame_err, fused_* and avg_en_* are 0 while reset is asserted.
  - Reset mid-frame discards all position state; the next accepted beat is beat 0 of frame 0.
- Handshake:
  - step = s_axis_tvalid & m_axis_tready.
  - No state changes without step.
  - Output is lock-stepped to input, so there is no internal skid buffer.
- Counters:
  - beat_cnt increments on step.
  - On step & s_axis_tlast, beat_cnt clears to 0 and frame_cnt increments, wrapping from 2*FUSE_COUNT-1 to 0.
  - A premature or late tlast sets frame_err but is still honoured as the frame end.
  - Without tlast, beat_cnt wraps at BEATS-1 to 0 and frame_cnt holds.
- Sobel event (step & beat_cnt==SOBEL_DELAY-1):
  - avg_add toggles.
  - avg_first <= (frame_cnt==0).
  - If frame_cnt==0: avg_out_sel toggles and avg_next <= 1.
  - If frame_cnt==2: avg_next <= 0.
- Average enables:
  - avg_cur = step & stage_ok[SOBEL_DELAY-1].
  - avg_en_a = avg_out_sel ? avg_cur : avg_cur & avg_next.
  - avg_en_b is the mirror image of avg_en_a.
- Fused event (step & beat_cnt==FUSED_DELAY-1):
  - fused_rd <= 1.
  - fused_wr <= 1.
  - store_sel <= (frame_cnt<2).
  - out_active <= (frame_cnt==2*FUSE_COUNT-1).
- Fused enables and select:
  - fused_rd_en = fused_rd & step; fused_wr_en = fused_wr & step.
  - fused_src_sel = (frame_cnt==0), combinational.
- tlast delay:
  - FUSED_DELAY-deep shift register of s_axis_tlast, advanced on step.
  - m_axis_tlast = last_d[FUSED_DELAY-1] & out_active.
  - m_axis_tvalid = step & out_active.
- Stage-valid chain:
  - stage_ok shifts in 1 on each step.
  - Once full, it stays all-ones until reset.
- Simultaneous events: a step with tlast on a Sobel or fused event beat evaluates the event using the pre-update frame_cnt.
- Constraint: FUSED_DELAY < BEATS. Violating parameters fail elaboration.

Decomposition:
- Package lrf_pkg: BEATS, FUSE_COUNT, counter widths, SOBEL_DELAY, FUSED_DELAY, MAX_DELAY constants.
- Sub-module lrf_step_delay (parameterised DEPTH shift register with step enable and async reset) is used for both the tlast delay and stage_ok.

Test Plan:
- Reset then 3 beats with tvalid=1 and m_axis_tready=0 -> step=0; beat_cnt and stage_ok stay 0.
- Stream 256 beats with tlast on beat 255, no stalls -> frame_cnt=1, beat_cnt=0, frame_err=0; at the beat_cnt==9 step, avg_add goes 1 and avg_out_sel toggles.
- Full burst of 32 frames -> m_axis_tvalid is asserted only from frame 31 beat 23 through frame 0 beat 22 of the next burst; m_axis_tlast appears 23 steps after frame 31's tlast.
- tlast at beat 100 -> frame_err=1 (sticky); frame_cnt increments; next beat is beat_cnt=0.
- Random m_axis_tready stalls (50%) over 2 bursts -> enable pulses occur only on steps; fused_wr_en counts equal 2*256-23 per frame-pair boundary versus the no-stall reference.
- Assert reset at frame 5 beat 40 -> all outputs return to reset values; the next frame restarts at frame_cnt=0 with avg_first=1.

Source files
------------

// File: rtl/lrf_pkg.sv
// Shared geometry and pipeline-alignment constants for the LRF fusion datapath.
package lrf_pkg;

   localparam int unsigned PIXELS_PER_BEAT = 16;
   localparam int unsigned IMAGE_DIM       = 64;
   localparam int unsigned N_FUSE_COUNT    = 4;
   localparam int unsigned SOBEL_DELAY     = 10;
   localparam int unsigned FUSED_DELAY     = 23;
   localparam int unsigned MAX_DELAY       = 30;

   localparam int unsigned BEATS      = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int unsigned FUSE_COUNT = 2 ** N_FUSE_COUNT;
   localparam int unsigned FRAMES     = 2 * FUSE_COUNT;
   localparam int unsigned BEAT_W     = $clog2(BEATS);
   localparam int unsigned FRAME_W    = $clog2(FRAMES);

endpackage

// File: rtl/lrf_step_delay.sv
// Step-enabled shift register; bit k holds the input as it was k+1 steps ago.
module lrf_step_delay #(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             step_i,
   input  logic             d_i,
   output logic [DEPTH-1:0] q_o
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   always_comb begin
      sr_d    = sr_q << 1;
      sr_d[0] = d_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else if (step_i) begin
         sr_q <= sr_d;
      end
   end

   assign q_o = sr_q;

endmodule

// File: rtl/lrf_fusion_sequencer.sv
// Control sequencer for the LRF fusion datapath: handshake, beat/frame position,
// pipeline-aligned buffer enables and the delayed output framing.
module lrf_fusion_sequencer
   import lrf_pkg::*;
(
   input  logic               s_axis_aclk,
   input  logic               s_axis_areset,
   input  logic               s_axis_tvalid,
   input  logic               s_axis_tlast,
   output logic               s_axis_tready,
   input  logic               m_axis_tready,
   output logic               m_axis_tvalid,
   output logic               m_axis_tlast,
   output logic               step,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic [BEAT_W-1:0]  beat_cnt,
   output logic               fused_src_sel,
   output logic               avg_first,
   output logic               avg_add,
   output logic               avg_en_a,
   output logic               avg_en_b,
   output logic               avg_out_sel,
   output logic               fused_rd_en,
   output logic               fused_wr_en,
   output logic               store_sel,
   output logic [MAX_DELAY-1:0] stage_ok,
   output logic               frame_err
);

   if (FUSED_DELAY >= BEATS || FUSED_DELAY == 0 || SOBEL_DELAY == 0 ||
       SOBEL_DELAY > MAX_DELAY) begin : g_bad_params
      $error("lrf_fusion_sequencer: illegal delay parameters");
   end

   logic [BEAT_W-1:0]  beat_cnt_q,  beat_cnt_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic frame_err_q,   frame_err_d;
   logic avg_add_q,     avg_add_d;
   logic avg_first_q,   avg_first_d;
   logic avg_out_sel_q, avg_out_sel_d;
   logic avg_next_q,    avg_next_d;
   logic fused_rd_q,    fused_rd_d;
   logic fused_wr_q,    fused_wr_d;
   logic store_sel_q,   store_sel_d;
   logic out_active_q,  out_active_d;

   logic step_c;
   logic sobel_evt, fused_evt, last_beat, last_frame, frame0;
   logic avg_cur;
   logic [FUSED_DELAY-1:0] last_dly;
   logic unused_last_dly;

   assign step_c     = s_axis_tvalid & m_axis_tready;
   assign sobel_evt  = step_c && (beat_cnt_q == BEAT_W'(SOBEL_DELAY - 1));
   assign fused_evt  = step_c && (beat_cnt_q == BEAT_W'(FUSED_DELAY - 1));
   assign last_beat  = (beat_cnt_q == BEAT_W'(BEATS - 1));
   assign last_frame = (frame_cnt_q == FRAME_W'(FRAMES - 1));
   assign frame0     = (frame_cnt_q == '0);

   // Next-state; events all look at the pre-update frame count.
   always_comb begin
      beat_cnt_d    = beat_cnt_q;
      frame_cnt_d   = frame_cnt_q;
      frame_err_d   = frame_err_q;
      avg_add_d     = avg_add_q;
      avg_first_d   = avg_first_q;
      avg_out_sel_d = avg_out_sel_q;
      avg_next_d    = avg_next_q;
      fused_rd_d    = fused_rd_q;
      fused_wr_d    = fused_wr_q;
      store_sel_d   = store_sel_q;
      out_active_d  = out_active_q;

      if (step_c) begin
         if (s_axis_tlast) begin
            beat_cnt_d  = '0;
            frame_cnt_d = last_frame ? '0 : frame_cnt_q + FRAME_W'(1);
            if (!last_beat) begin
               frame_err_d = 1'b1;
            end
         end else begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
         end
      end

      if (sobel_evt) begin
         avg_add_d   = ~avg_add_q;
         avg_first_d = frame0;
         if (frame0) begin
            avg_out_sel_d = ~avg_out_sel_q;
            avg_next_d    = 1'b1;
         end
         if (frame_cnt_q == FRAME_W'(2)) begin
            avg_next_d = 1'b0;
         end
      end

      if (fused_evt) begin
         fused_rd_d   = 1'b1;
         fused_wr_d   = 1'b1;
         store_sel_d  = (frame_cnt_q < FRAME_W'(2));
         out_active_d = last_frame;
      end
   end

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         beat_cnt_q    <= '0;
         frame_cnt_q   <= '0;
         frame_err_q   <= 1'b0;
         avg_add_q     <= 1'b0;
         avg_first_q   <= 1'b1;
         avg_out_sel_q <= 1'b0;
         avg_next_q    <= 1'b1;
         fused_rd_q    <= 1'b0;
         fused_wr_q    <= 1'b0;
         store_sel_q   <= 1'b0;
         out_active_q  <= 1'b0;
      end else begin
         beat_cnt_q    <= beat_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         frame_err_q   <= frame_err_d;
         avg_add_q     <= avg_add_d;
         avg_first_q   <= avg_first_d;
         avg_out_sel_q <= avg_out_sel_d;
         avg_next_q    <= avg_next_d;
         fused_rd_q    <= fused_rd_d;
         fused_wr_q    <= fused_wr_d;
         store_sel_q   <= store_sel_d;
         out_active_q  <= out_active_d;
      end
   end

   lrf_step_delay #(.DEPTH(FUSED_DELAY)) u_tlast_dly (
      .clk_i  (s_axis_aclk),
      .rst_i  (s_axis_areset),
      .step_i (step_c),
      .d_i    (s_axis_tlast),
      .q_o    (last_dly)
   );

   lrf_step_delay #(.DEPTH(MAX_DELAY)) u_stage_ok (
      .clk_i  (s_axis_aclk),
      .rst_i  (s_axis_areset),
      .step_i (step_c),
      .d_i    (1'b1),
      .q_o    (stage_ok)
   );

   // Only the final tap of the tlast delay feeds the output.
   assign unused_last_dly = ^last_dly[FUSED_DELAY-2:0];

   assign avg_cur = step_c & stage_ok[SOBEL_DELAY-1];

   assign s_axis_tready = m_axis_tready;
   assign step          = step_c;
   assign frame_cnt     = frame_cnt_q;
   assign beat_cnt      = beat_cnt_q;
   assign frame_err     = frame_err_q;
   assign avg_add       = avg_add_q;
   assign avg_first     = avg_first_q;
   assign avg_out_sel   = avg_out_sel_q;
   assign avg_en_a      = avg_out_sel_q ? avg_cur : (avg_cur & avg_next_q);
   assign avg_en_b      = avg_out_sel_q ? (avg_cur & avg_next_q) : avg_cur;
   assign fused_rd_en   = fused_rd_q & step_c;
   assign fused_wr_en   = fused_wr_q & step_c;
   assign store_sel     = store_sel_q;
   assign fused_src_sel = frame0;
   assign m_axis_tvalid = step_c & out_active_q;
   assign m_axis_tlast  = last_dly[FUSED_DELAY-1] & out_active_q;

endmodule
